// File: rtl/best_1ofn_cclut_pipe_pkg.sv
// Shared widths and helpers for the ccLUT best-pattern sorter tree.
// Sort-field extraction and pipeline-mask popcount are used by both the node and the top.
package ccLUT_sort_pkg;

  localparam int DEF_MXPATB = 7;
  localparam int DEF_MXPATC = 11;
  // Widest pattern word the sort helpers accept; callers zero-extend into it.
  localparam int PATW       = 16;

  function automatic logic [PATW-1:0] sort_field(input logic [PATW-1:0] p, input bit ignore_lsb);
    return ignore_lsb ? (p >> 1) : p;
  endfunction

  function automatic int popcount(input logic [31:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m[i]);
    return n;
  endfunction

endpackage

// File: rtl/best_1ofn_cclut_pipe_if.sv
// Candidate bus into the best-of-N sorter and the winner bus out of it.
interface best_1ofn_cclut_pipe_if
  import ccLUT_sort_pkg::*;
#(
  parameter int NKEY   = 32,
  parameter int MXPATB = DEF_MXPATB,
  parameter int MXPATC = DEF_MXPATC
);
  localparam int MXKEYB = $clog2(NKEY);

  logic [NKEY*MXPATB-1:0] pat_in;
  logic [NKEY*MXPATC-1:0] carry_in;
  logic                   in_vld;
  logic [MXPATB-2:0]      pat_thresh;
  logic [MXPATB-1:0]      best_pat;
  logic [MXKEYB-1:0]      best_key;
  logic [MXPATC-1:0]      best_carry;
  logic                   best_vld;
  logic                   best_hit;

  modport master (
    output pat_in, carry_in, in_vld, pat_thresh,
    input  best_pat, best_key, best_carry, best_vld, best_hit
  );

  modport slave (
    input  pat_in, carry_in, in_vld, pat_thresh,
    output best_pat, best_key, best_carry, best_vld, best_hit
  );

endinterface

// File: rtl/best_1of2_cclut_node.sv
// One compare-by-two node: upper input wins only on a strictly larger sort field.
// Prepends the select bit as the new key MSB; optional output register with sync reset.
module best_1of2_cclut_node
  import ccLUT_sort_pkg::*;
#(
  parameter int KW         = 1,
  parameter int MXPATB     = DEF_MXPATB,
  parameter int MXPATC     = DEF_MXPATC,
  parameter bit REG        = 1'b0,
  parameter bit IGNORE_LSB = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [MXPATB-1:0] pat_lo_i,
  input  logic [KW-1:0]     key_lo_i,
  input  logic [MXPATC-1:0] carry_lo_i,
  input  logic [MXPATB-1:0] pat_hi_i,
  input  logic [KW-1:0]     key_hi_i,
  input  logic [MXPATC-1:0] carry_hi_i,
  output logic [MXPATB-1:0] pat_o,
  output logic [KW-1:0]     key_o,
  output logic [MXPATC-1:0] carry_o
);

  logic              sel;
  logic [MXPATB-1:0] pat_d;
  logic [KW-1:0]     key_d;
  logic [MXPATC-1:0] carry_d;

  // Input keys arrive with a spare zero MSB that is overwritten by the select bit.
  always_comb begin
    sel     = sort_field(PATW'(pat_hi_i), IGNORE_LSB) > sort_field(PATW'(pat_lo_i), IGNORE_LSB);
    pat_d   = sel ? pat_hi_i   : pat_lo_i;
    carry_d = sel ? carry_hi_i : carry_lo_i;
    key_d   = sel ? key_hi_i   : key_lo_i;
    key_d[KW-1] = sel;
  end

  if (REG) begin : g_reg
    logic [MXPATB-1:0] pat_q;
    logic [KW-1:0]     key_q;
    logic [MXPATC-1:0] carry_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        pat_q   <= '0;
        key_q   <= '0;
        carry_q <= '0;
      end else begin
        pat_q   <= pat_d;
        key_q   <= key_d;
        carry_q <= carry_d;
      end
    end

    assign pat_o   = pat_q;
    assign key_o   = key_q;
    assign carry_o = carry_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clock | reset;
    assign pat_o   = pat_d;
    assign key_o   = key_d;
    assign carry_o = carry_d;
  end

endmodule

// File: rtl/best_1ofn_cclut_pipe.sv
// Best-of-NKEY ccLUT pattern sorter: binary tree, registers at levels chosen by PIPE_MASK.
// Latency popcount(PIPE_MASK), throughput one set per clock, no backpressure.
module best_1ofn_cclut_pipe
  import ccLUT_sort_pkg::*;
#(
  parameter int          NKEY       = 32,
  parameter int          MXPATB     = DEF_MXPATB,
  parameter int          MXPATC     = DEF_MXPATC,
  parameter int unsigned PIPE_MASK  = 5'b01000,
  parameter bit          IGNORE_LSB = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  best_1ofn_cclut_pipe_if.slave  bus
);

  localparam int MXKEYB = $clog2(NKEY);
  localparam int NLEVEL = MXKEYB;
  localparam int LAST   = NLEVEL - 1;
  localparam int LAT    = popcount(32'(PIPE_MASK) & ((32'd1 << NLEVEL) - 32'd1));

  for (genvar L = 0; L < NLEVEL; L++) begin : g_lvl
    localparam int NN  = NKEY >> (L + 1);
    localparam bit REG = ((PIPE_MASK >> L) & 1) != 0;

    logic [MXPATB-1:0] pat_src   [2*NN];
    logic [L:0]        key_src   [2*NN];
    logic [MXPATC-1:0] carry_src [2*NN];
    logic              vld_src;

    logic [MXPATB-1:0] pat_lvl   [NN];
    logic [L:0]        key_lvl   [NN];
    logic [MXPATC-1:0] carry_lvl [NN];
    logic              vld_lvl;

    if (L == 0) begin : g_src
      for (genvar i = 0; i < 2*NN; i++) begin : g_in
        assign pat_src[i]   = bus.pat_in[i*MXPATB +: MXPATB];
        assign carry_src[i] = bus.carry_in[i*MXPATC +: MXPATC];
        assign key_src[i]   = 1'b0;
      end
      assign vld_src = bus.in_vld;
    end else begin : g_src
      for (genvar i = 0; i < 2*NN; i++) begin : g_in
        assign pat_src[i]   = g_lvl[L-1].pat_lvl[i];
        assign carry_src[i] = g_lvl[L-1].carry_lvl[i];
        assign key_src[i]   = {1'b0, g_lvl[L-1].key_lvl[i]};
      end
      assign vld_src = g_lvl[L-1].vld_lvl;
    end

    for (genvar n = 0; n < NN; n++) begin : g_node
      best_1of2_cclut_node #(
        .KW         (L + 1),
        .MXPATB     (MXPATB),
        .MXPATC     (MXPATC),
        .REG        (REG),
        .IGNORE_LSB (IGNORE_LSB)
      ) u_node (
        .clock      (clock),
        .reset      (reset),
        .pat_lo_i   (pat_src[2*n]),
        .key_lo_i   (key_src[2*n]),
        .carry_lo_i (carry_src[2*n]),
        .pat_hi_i   (pat_src[2*n+1]),
        .key_hi_i   (key_src[2*n+1]),
        .carry_hi_i (carry_src[2*n+1]),
        .pat_o      (pat_lvl[n]),
        .key_o      (key_lvl[n]),
        .carry_o    (carry_lvl[n])
      );
    end

    // Valid shifts only at registered levels so it stays aligned with the data.
    if (REG) begin : g_vreg
      logic vld_q;
      always_ff @(posedge clock) begin
        if (reset) vld_q <= 1'b0;
        else       vld_q <= vld_src;
      end
      assign vld_lvl = vld_q;
    end else begin : g_vcomb
      assign vld_lvl = vld_src;
    end
  end

  logic vld_fin;

  if (LAT == 0) begin : g_vld_comb
    assign vld_fin = g_lvl[LAST].vld_lvl & ~reset;
  end else begin : g_vld_reg
    assign vld_fin = g_lvl[LAST].vld_lvl;
  end

  assign bus.best_pat   = g_lvl[LAST].pat_lvl[0];
  assign bus.best_key   = g_lvl[LAST].key_lvl[0];
  assign bus.best_carry = g_lvl[LAST].carry_lvl[0];
  assign bus.best_vld   = vld_fin;
  assign bus.best_hit   = vld_fin &&
      (sort_field(PATW'(g_lvl[LAST].pat_lvl[0]), IGNORE_LSB) >= PATW'(bus.pat_thresh));

endmodule

// File: tb/tb_best_1ofn_cclut_pipe.sv
// Bench for best_1ofn_cclut_pipe: three configurations (LAT=1 lsb-ignored, LAT=3 full word,
// 256-key LAT=0) checked against a linear-scan reference of "highest sort field, lowest key".
module tb_best_1ofn_cclut_pipe;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  best_1ofn_cclut_pipe_if #(.NKEY(32),  .MXPATB(7), .MXPATC(11)) if_a ();
  best_1ofn_cclut_pipe_if #(.NKEY(32),  .MXPATB(7), .MXPATC(11)) if_b ();
  best_1ofn_cclut_pipe_if #(.NKEY(256), .MXPATB(7), .MXPATC(11)) if_c ();

  best_1ofn_cclut_pipe #(.NKEY(32), .MXPATB(7), .MXPATC(11), .PIPE_MASK(5'b01000), .IGNORE_LSB(1'b1))
    dut_a (.clock(clk), .reset(rst), .bus(if_a.slave));
  best_1ofn_cclut_pipe #(.NKEY(32), .MXPATB(7), .MXPATC(11), .PIPE_MASK(5'b10101), .IGNORE_LSB(1'b0))
    dut_b (.clock(clk), .reset(rst), .bus(if_b.slave));
  best_1ofn_cclut_pipe #(.NKEY(256), .MXPATB(7), .MXPATC(11), .PIPE_MASK(0), .IGNORE_LSB(1'b1))
    dut_c (.clock(clk), .reset(rst), .bus(if_c.slave));

  typedef struct {
    int key;
    int pat;
    int carry;
    bit hit;
  } exp_t;

  int   n_chk;
  int   n_fail;
  int   pa [256];
  int   ca [256];
  exp_t q_exp [$];

  // Reference: scan keys upward, replace the leader only on a strictly larger sort field.
  function automatic exp_t ref_best(input int p[256], input int c[256], input int n,
                                    input bit ign, input int thr);
    exp_t e;
    int   best;
    int   sb;
    best = 0;
    for (int k = 1; k < n; k++) begin
      if ((ign ? p[k] / 2 : p[k]) > (ign ? p[best] / 2 : p[best])) best = k;
    end
    sb      = ign ? p[best] / 2 : p[best];
    e.key   = best;
    e.pat   = p[best];
    e.carry = c[best];
    e.hit   = (sb >= thr);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_buf();
    for (int k = 0; k < 256; k++) begin
      pa[k] = 0;
      ca[k] = int'($urandom_range(0, 2047));
    end
  endtask

  task automatic rand_buf(input int n, input bool_tie);
    for (int k = 0; k < 256; k++) begin
      if (k < n) pa[k] = bool_tie ? int'($urandom_range(96, 99)) : int'($urandom_range(0, 127));
      else       pa[k] = 0;
      ca[k] = int'($urandom_range(0, 2047));
    end
  endtask

  task automatic apply_a(input bit vld);
    for (int k = 0; k < 32; k++) begin
      if_a.pat_in[k*7 +: 7]    = 7'(pa[k]);
      if_a.carry_in[k*11 +: 11] = 11'(ca[k]);
    end
    if_a.in_vld = vld;
  endtask

  task automatic apply_b(input bit vld);
    for (int k = 0; k < 32; k++) begin
      if_b.pat_in[k*7 +: 7]    = 7'(pa[k]);
      if_b.carry_in[k*11 +: 11] = 11'(ca[k]);
    end
    if_b.in_vld = vld;
  endtask

  task automatic apply_c(input bit vld);
    for (int k = 0; k < 256; k++) begin
      if_c.pat_in[k*7 +: 7]    = 7'(pa[k]);
      if_c.carry_in[k*11 +: 11] = 11'(ca[k]);
    end
    if_c.in_vld = vld;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.pat_thresh = '0;
    if_b.pat_thresh = '0;
    if_c.pat_thresh = '0;
    clear_buf();
    pa[5] = 7'h33;
    apply_a(1'b1);
    apply_b(1'b1);
    apply_c(1'b1);
    tick();
    tick();
    n_chk++;
    if ({if_a.best_pat, if_a.best_key, if_a.best_carry, if_a.best_vld, if_a.best_hit} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_a: got pat=%h key=%0d carry=%h vld=%b hit=%b, want all 0",
               if_a.best_pat, if_a.best_key, if_a.best_carry, if_a.best_vld, if_a.best_hit);
    end
    n_chk++;
    if ({if_b.best_pat, if_b.best_key, if_b.best_carry, if_b.best_vld, if_b.best_hit} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_b: got pat=%h key=%0d carry=%h vld=%b hit=%b, want all 0",
               if_b.best_pat, if_b.best_key, if_b.best_carry, if_b.best_vld, if_b.best_hit);
    end
    n_chk++;
    if ({if_c.best_vld, if_c.best_hit} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_c_vld: got vld=%b hit=%b, want 0 0", if_c.best_vld, if_c.best_hit);
    end
    n_chk++;
    if ({if_c.best_pat, if_c.best_key} !== {7'h33, 8'd5}) begin
      n_fail++;
      $display("FAIL reset_c_data: got pat=%h key=%0d, want 33 5", if_c.best_pat, if_c.best_key);
    end
    rst = 1'b0;
    apply_a(1'b0);
    apply_b(1'b0);
    apply_c(1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_chk++;
    if ({if_a.best_vld, if_b.best_vld, if_c.best_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_vld: got a=%b b=%b c=%b, want 0 0 0", if_a.best_vld, if_b.best_vld, if_c.best_vld);
    end
  endtask

  task automatic test_single_key();
    clear_buf();
    pa[17] = 7'h5A;
    apply_a(1'b1);
    tick();
    n_chk++;
    if ({if_a.best_key, if_a.best_pat, if_a.best_carry, if_a.best_vld, if_a.best_hit} !==
        {5'd17, 7'h5A, 11'(ca[17]), 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_key: got key=%0d pat=%h carry=%h vld=%b hit=%b, want 17 5a %h 1 1",
               if_a.best_key, if_a.best_pat, if_a.best_carry, if_a.best_vld, if_a.best_hit, 11'(ca[17]));
    end
    apply_a(1'b0);
    tick();
    n_chk++;
    if ({if_a.best_vld, if_a.best_hit} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_gap: got vld=%b hit=%b, want 0 0", if_a.best_vld, if_a.best_hit);
    end
  endtask

  task automatic test_tie();
    clear_buf();
    pa[3]  = 7'h4C;
    pa[20] = 7'h4C;
    pa[9]  = 7'h4D;
    apply_a(1'b1);
    apply_b(1'b1);
    tick();
    n_chk++;
    if ({if_a.best_key, if_a.best_pat} !== {5'd3, 7'h4C}) begin
      n_fail++;
      $display("FAIL tie_lsb_ignored: got key=%0d pat=%h, want 3 4c", if_a.best_key, if_a.best_pat);
    end
    apply_a(1'b0);
    apply_b(1'b0);
    tick();
    n_chk++;
    if (if_b.best_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_b_early: got vld=%b at 2 cycles, want 0", if_b.best_vld);
    end
    tick();
    n_chk++;
    if ({if_b.best_key, if_b.best_pat, if_b.best_vld} !== {5'd9, 7'h4D, 1'b1}) begin
      n_fail++;
      $display("FAIL tie_full_word: got key=%0d pat=%h vld=%b, want 9 4d 1",
               if_b.best_key, if_b.best_pat, if_b.best_vld);
    end
    clear_buf();
    pa[100] = 7'h61;
    pa[200] = 7'h60;
    apply_c(1'b1);
    #1;
    n_chk++;
    if ({if_c.best_key, if_c.best_pat} !== {8'd100, 7'h61}) begin
      n_fail++;
      $display("FAIL tie_wide: got key=%0d pat=%h, want 100 61", if_c.best_key, if_c.best_pat);
    end
    apply_c(1'b0);
    tick();
  endtask

  task automatic test_thresh();
    clear_buf();
    pa[7]  = 7'h25;
    pa[30] = 7'h24;
    pa[2]  = 7'h11;
    if_a.pat_thresh = 6'h13;
    tick();
    apply_a(1'b1);
    tick();
    n_chk++;
    if ({if_a.best_vld, if_a.best_hit, if_a.best_key} !== {1'b1, 1'b0, 5'd7}) begin
      n_fail++;
      $display("FAIL thresh_above: got vld=%b hit=%b key=%0d, want 1 0 7",
               if_a.best_vld, if_a.best_hit, if_a.best_key);
    end
    apply_a(1'b0);
    if_a.pat_thresh = 6'h12;
    tick();
    apply_a(1'b1);
    tick();
    n_chk++;
    if ({if_a.best_vld, if_a.best_hit} !== 2'b11) begin
      n_fail++;
      $display("FAIL thresh_equal: got vld=%b hit=%b, want 1 1", if_a.best_vld, if_a.best_hit);
    end
    apply_a(1'b0);
    tick();
    n_chk++;
    if (if_a.best_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL thresh_novld: got hit=%b without vld, want 0", if_a.best_hit);
    end
  endtask

  task automatic test_all_zero();
    clear_buf();
    if_a.pat_thresh = 6'h01;
    tick();
    apply_a(1'b1);
    tick();
    n_chk++;
    if ({if_a.best_pat, if_a.best_key, if_a.best_vld, if_a.best_hit} !== {7'h00, 5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL all_zero: got pat=%h key=%0d vld=%b hit=%b, want 0 0 1 0",
               if_a.best_pat, if_a.best_key, if_a.best_vld, if_a.best_hit);
    end
    apply_a(1'b0);
    tick();
  endtask

  task automatic test_random_a();
    exp_t e;
    int   thr;
    thr = int'($urandom_range(0, 63));
    if_a.pat_thresh = 6'(thr);
    tick();
    for (int i = 0; i < 200; i++) begin
      rand_buf(32, (i % 3) == 0);
      e = ref_best(pa, ca, 32, 1'b1, thr);
      apply_a(1'b1);
      tick();
      n_chk++;
      if ({if_a.best_pat, if_a.best_key, if_a.best_carry, if_a.best_vld, if_a.best_hit} !==
          {7'(e.pat), 5'(e.key), 11'(e.carry), 1'b1, e.hit}) begin
        n_fail++;
        $display("FAIL random_a[%0d]: got pat=%h key=%0d carry=%h vld=%b hit=%b, want %h %0d %h 1 %b", i,
                 if_a.best_pat, if_a.best_key, if_a.best_carry, if_a.best_vld, if_a.best_hit,
                 7'(e.pat), e.key, 11'(e.carry), e.hit);
      end
    end
    apply_a(1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   thr;
    thr = int'($urandom_range(40, 110));
    if_b.pat_thresh = 6'(thr);
    apply_b(1'b0);
    for (int i = 0; i < 4; i++) tick();
    q_exp.delete();
    for (int j = 0; j < 1002; j++) begin
      if (j < 1000) begin
        rand_buf(32, (j % 2) == 0);
        q_exp.push_back(ref_best(pa, ca, 32, 1'b0, thr % 64));
        apply_b(1'b1);
      end else begin
        apply_b(1'b0);
      end
      tick();
      if (j < 2) begin
        n_chk++;
        if (if_b.best_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_early[%0d]: got vld=%b, want 0", j, if_b.best_vld);
        end
      end else begin
        e = q_exp.pop_front();
        n_chk++;
        if ({if_b.best_vld, if_b.best_hit} !== {1'b1, e.hit}) begin
          n_fail++;
          $display("FAIL stream_vld[%0d]: got vld=%b hit=%b, want 1 %b", j - 2,
                   if_b.best_vld, if_b.best_hit, e.hit);
        end
        n_chk++;
        if ({if_b.best_pat, if_b.best_key, if_b.best_carry} !== {7'(e.pat), 5'(e.key), 11'(e.carry)}) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: got pat=%h key=%0d carry=%h, want %h %0d %h", j - 2,
                   if_b.best_pat, if_b.best_key, if_b.best_carry, 7'(e.pat), e.key, 11'(e.carry));
        end
      end
    end
    tick();
    n_chk++;
    if (if_b.best_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_tail: got vld=%b after last entry, want 0", if_b.best_vld);
    end
  endtask

  task automatic test_reset_midstream();
    clear_buf();
    pa[12] = 7'h70;
    if_b.pat_thresh = '0;
    apply_b(1'b1);
    tick();
    apply_b(1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if ({if_b.best_pat, if_b.best_key, if_b.best_carry, if_b.best_vld, if_b.best_hit} !== 25'd0) begin
        n_fail++;
        $display("FAIL midreset_hold[%0d]: got pat=%h key=%0d carry=%h vld=%b hit=%b, want all 0", i,
                 if_b.best_pat, if_b.best_key, if_b.best_carry, if_b.best_vld, if_b.best_hit);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (if_b.best_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_discard[%0d]: got vld=%b, want 0", i, if_b.best_vld);
      end
    end
    apply_b(1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      apply_b(1'b0);
      n_chk++;
      if (if_b.best_vld !== (i == 3)) begin
        n_fail++;
        $display("FAIL midreset_latency[%0d]: got vld=%b, want %b", i, if_b.best_vld, i == 3);
      end
    end
    n_chk++;
    if ({if_b.best_key, if_b.best_pat} !== {5'd12, 7'h70}) begin
      n_fail++;
      $display("FAIL midreset_data: got key=%0d pat=%h, want 12 70", if_b.best_key, if_b.best_pat);
    end
  endtask

  task automatic test_wide();
    exp_t e;
    int   thr;
    clear_buf();
    pa[223] = 7'h7E;
    pa[10]  = 7'h7C;
    if_c.pat_thresh = '0;
    apply_c(1'b1);
    #1;
    n_chk++;
    if ({if_c.best_key, if_c.best_pat, if_c.best_carry, if_c.best_vld, if_c.best_hit} !==
        {8'd223, 7'h7E, 11'(ca[223]), 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_key223: got key=%0d pat=%h carry=%h vld=%b hit=%b, want 223 7e %h 1 1",
               if_c.best_key, if_c.best_pat, if_c.best_carry, if_c.best_vld, if_c.best_hit, 11'(ca[223]));
    end
    for (int i = 0; i < 30; i++) begin
      thr = int'($urandom_range(0, 63));
      if_c.pat_thresh = 6'(thr);
      rand_buf(224, (i % 2) == 0);
      e = ref_best(pa, ca, 256, 1'b1, thr);
      apply_c(1'b1);
      #2;
      n_chk++;
      if ({if_c.best_pat, if_c.best_key, if_c.best_carry, if_c.best_vld, if_c.best_hit} !==
          {7'(e.pat), 8'(e.key), 11'(e.carry), 1'b1, e.hit}) begin
        n_fail++;
        $display("FAIL wide_rand[%0d]: got pat=%h key=%0d carry=%h vld=%b hit=%b, want %h %0d %h 1 %b", i,
                 if_c.best_pat, if_c.best_key, if_c.best_carry, if_c.best_vld, if_c.best_hit,
                 7'(e.pat), e.key, 11'(e.carry), e.hit);
      end
    end
    apply_c(1'b0);
    #1;
    n_chk++;
    if (if_c.best_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_idle: got vld=%b, want 0", if_c.best_vld);
    end
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    test_reset();
    test_single_key();
    test_tie();
    test_thresh();
    test_all_zero();
    test_random_a();
    test_back_to_back();
    test_reset_midstream();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
